// File: rtl/ysyx_22050078_mem_arbiter_pkg.sv
// Shared encodings and default widths for the IF/LS physical-memory arbiter.
package ysyx_22050078_mem_arbiter_pkg;

    localparam int CPU_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Owner value doubles as the bit index into the one-hot grant vector.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    function automatic int wdog_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050078_mem_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory model.
interface ysyx_22050078_mem_arbiter_if
    import ysyx_22050078_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = CPU_WIDTH,
    parameter int DATA_W = CPU_WIDTH
);

    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_W-1:0]     ls_addr;
    logic                  ls_wen;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_wmask;
    logic                  ls_rsp_valid;
    logic [DATA_W-1:0]     ls_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  err;

    // Arbiter view: serves the requesters and drives the memory request.
    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output err
    );

    // Environment view: requesters plus the memory model.
    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  err
    );

endinterface

// File: rtl/ysyx_22050078_rr_arb2.sv
// Two-way round-robin picker: on a tie, grants the requester not granted last.
module ysyx_22050078_rr_arb2
    import ysyx_22050078_mem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  owner_t     last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_22050078_mem_arbiter.sv
// Shares the single memory port between IF and LS, one transaction at a time,
// with a watchdog that aborts a transaction whose response never arrives.
module ysyx_22050078_mem_arbiter
    import ysyx_22050078_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = CPU_WIDTH,
    parameter int DATA_W  = CPU_WIDTH,
    parameter int TIMEOUT = 256
)(
    input  logic                         clk,
    input  logic                         rst_n,
    ysyx_22050078_mem_arbiter_if.slave   bus
);

    localparam int                MASK_W   = DATA_W / 8;
    localparam int                CNT_W    = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t          state_q;
    arb_state_t          state_d;
    owner_t              owner_q;
    owner_t              last_owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;

    logic [1:0]          grant;
    logic                accept;
    logic                rsp_done;
    logic                timeout;

    ysyx_22050078_rr_arb2 u_rr_arb2 (
        .valid      ({bus.ls_req_valid, bus.if_req_valid}),
        .last_owner (last_owner_q),
        .grant      (grant)
    );

    assign accept   = (state_q == ST_IDLE) && (grant != 2'b00);
    assign rsp_done = (state_q == ST_WAIT) && bus.mem_rsp_valid;
    // A response landing on the last allowed cycle completes normally.
    assign timeout  = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && !rsp_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: if (rsp_done || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            // Counter runs only while a transaction is in flight.
            if (state_q == ST_IDLE || state_d == ST_IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) begin
                if (grant[OWN_LS]) begin
                    owner_q      <= OWN_LS;
                    last_owner_q <= OWN_LS;
                    addr_q       <= bus.ls_addr;
                    wen_q        <= bus.ls_wen;
                    wdata_q      <= bus.ls_wdata;
                    wmask_q      <= bus.ls_wmask;
                end else begin
                    owner_q      <= OWN_IF;
                    last_owner_q <= OWN_IF;
                    addr_q       <= bus.if_addr;
                    wen_q        <= 1'b0;
                    wdata_q      <= '0;
                    wmask_q      <= '0;
                end
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;

    // Strobes are masked during reset so an abandoned transaction never answers.
    always_comb begin
        bus.if_req_ready  = 1'b0;
        bus.ls_req_ready  = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.if_rsp_valid  = 1'b0;
        bus.if_rdata      = '0;
        bus.ls_rsp_valid  = 1'b0;
        bus.ls_rdata      = '0;
        bus.err           = 1'b0;
        if (rst_n) begin
            if (state_q == ST_IDLE) begin
                bus.if_req_ready = grant[OWN_IF];
                bus.ls_req_ready = grant[OWN_LS];
            end
            bus.mem_req_valid = (state_q == ST_REQ);
            if (rsp_done || timeout) begin
                if (owner_q == OWN_LS) begin
                    bus.ls_rsp_valid = 1'b1;
                    bus.ls_rdata     = rsp_done ? bus.mem_rdata : '0;
                end else begin
                    bus.if_rsp_valid = 1'b1;
                    bus.if_rdata     = rsp_done ? bus.mem_rdata : '0;
                end
            end
            bus.err = timeout;
        end
    end

endmodule

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_ysyx_22050078_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050078_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ysyx_22050078_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    // Reference model: one outstanding transaction, its age and who it belongs to.
    bit            m_busy, m_issued, m_owner_ls, m_last_ls;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;

    // Outputs observed in the most recent cycle.
    logic          o_if_ready, o_ls_ready, o_mem_valid, o_mem_wen;
    logic          o_if_rsp, o_ls_rsp, o_err;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, o_if_rdata, o_ls_rdata;
    logic [MW-1:0] o_mem_wmask;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_addr       = '0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = '0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = '0;
        bus.ls_wmask      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    // One clock cycle: sample mid-cycle, compare with the model, advance the model.
    task automatic step();
        bit gi, gl, fire_ok, fire_to, exp_if, exp_ls;
        @(negedge clk);
        o_if_ready  = bus.if_req_ready;
        o_ls_ready  = bus.ls_req_ready;
        o_mem_valid = bus.mem_req_valid;
        o_mem_addr  = bus.mem_addr;
        o_mem_wen   = bus.mem_wen;
        o_mem_wdata = bus.mem_wdata;
        o_mem_wmask = bus.mem_wmask;
        o_if_rsp    = bus.if_rsp_valid;
        o_if_rdata  = bus.if_rdata;
        o_ls_rsp    = bus.ls_rsp_valid;
        o_ls_rdata  = bus.ls_rdata;
        o_err       = bus.err;
        if (!rst_n) begin
            chk("rst_if_req_ready", 64'(o_if_ready), 64'(0));
            chk("rst_ls_req_ready", 64'(o_ls_ready), 64'(0));
            chk("rst_mem_req_valid", 64'(o_mem_valid), 64'(0));
            chk("rst_if_rsp_valid", 64'(o_if_rsp), 64'(0));
            chk("rst_ls_rsp_valid", 64'(o_ls_rsp), 64'(0));
            chk("rst_if_rdata", o_if_rdata, 64'(0));
            chk("rst_ls_rdata", o_ls_rdata, 64'(0));
            chk("rst_err", 64'(o_err), 64'(0));
            m_busy = 0; m_issued = 0; m_owner_ls = 0; m_last_ls = 0; m_age = 0;
            m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        end else begin
            gi = 0;
            gl = 0;
            if (!m_busy) begin
                if (bus.if_req_valid && bus.ls_req_valid) begin
                    gl = !m_last_ls;
                    gi = m_last_ls;
                end else begin
                    gi = bus.if_req_valid;
                    gl = bus.ls_req_valid;
                end
            end
            fire_ok = m_busy && m_issued && bus.mem_rsp_valid;
            fire_to = m_busy && !fire_ok && (m_age == TO - 1);
            exp_if  = (fire_ok || fire_to) && !m_owner_ls;
            exp_ls  = (fire_ok || fire_to) && m_owner_ls;
            chk("if_req_ready", 64'(o_if_ready), 64'(gi));
            chk("ls_req_ready", 64'(o_ls_ready), 64'(gl));
            chk("mem_req_valid", 64'(o_mem_valid), 64'(m_busy && !m_issued));
            chk("mem_addr", o_mem_addr, m_addr);
            chk("mem_wen", 64'(o_mem_wen), 64'(m_wen));
            chk("mem_wmask", 64'(o_mem_wmask), 64'(m_wmask));
            if (m_wen) chk("mem_wdata", o_mem_wdata, m_wdata);
            chk("if_rsp_valid", 64'(o_if_rsp), 64'(exp_if));
            chk("ls_rsp_valid", 64'(o_ls_rsp), 64'(exp_ls));
            chk("err", 64'(o_err), 64'(fire_to));
            if (exp_if) chk("if_rdata", o_if_rdata, fire_ok ? bus.mem_rdata : 64'(0));
            else if (m_busy && m_owner_ls) chk("if_rdata_nonowner", o_if_rdata, 64'(0));
            if (exp_ls) chk("ls_rdata", o_ls_rdata, fire_ok ? bus.mem_rdata : 64'(0));
            else if (m_busy && !m_owner_ls) chk("ls_rdata_nonowner", o_ls_rdata, 64'(0));
            if (fire_ok || fire_to) begin
                m_busy = 0;
            end else if (m_busy) begin
                if (!m_issued && bus.mem_req_ready) m_issued = 1;
                m_age++;
            end
            if (gi || gl) begin
                m_busy = 1; m_issued = 0; m_age = 0;
                m_owner_ls = gl; m_last_ls = gl;
                m_addr  = gl ? bus.ls_addr : bus.if_addr;
                m_wen   = gl ? bus.ls_wen : 1'b0;
                m_wdata = gl ? bus.ls_wdata : '0;
                m_wmask = gl ? bus.ls_wmask : '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive memory for an already-accepted request: rd cycles of backpressure,
    // sd idle WAIT cycles, then the response with data.
    task automatic serve(input int rd, input int sd, input logic [63:0] data);
        bus.mem_req_ready = 1'b0;
        repeat (rd) step();
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        repeat (sd) step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = data;
        step();
        bus.mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit hit after %0d checks", n_chk);
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Tie out of reset: LS, then IF, then LS.
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0100;
        bus.ls_req_valid = 1'b1; bus.ls_addr = 64'h8000_2000; bus.ls_wen = 1'b0;
        step();
        chk("tie1_ls_ready", 64'(o_ls_ready), 64'(1));
        chk("tie1_if_ready", 64'(o_if_ready), 64'(0));
        serve(0, 0, 64'h1111_2222_3333_4444);
        chk("tie1_ls_rsp", 64'(o_ls_rsp), 64'(1));
        chk("tie1_ls_rdata", o_ls_rdata, 64'h1111_2222_3333_4444);
        chk("tie1_if_rsp", 64'(o_if_rsp), 64'(0));
        step();
        chk("tie2_if_ready", 64'(o_if_ready), 64'(1));
        chk("tie2_ls_ready", 64'(o_ls_ready), 64'(0));
        serve(1, 1, 64'h5555_6666_7777_8888);
        chk("tie2_if_rsp", 64'(o_if_rsp), 64'(1));
        chk("tie2_if_rdata", o_if_rdata, 64'h5555_6666_7777_8888);
        chk("tie2_ls_rsp", 64'(o_ls_rsp), 64'(0));
        step();
        chk("tie3_ls_ready", 64'(o_ls_ready), 64'(1));
        serve(0, 2, 64'h9999_AAAA_BBBB_CCCC);
        chk("tie3_ls_rsp", 64'(o_ls_rsp), 64'(1));
        chk("tie3_ls_rdata", o_ls_rdata, 64'h9999_AAAA_BBBB_CCCC);
        idle_inputs();

        // IF only, memory ready immediately, response two cycles after accept.
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0000; bus.mem_req_ready = 1'b1;
        step();
        chk("ifo_accept", 64'(o_if_ready), 64'(1));
        bus.if_req_valid = 1'b0;
        step();
        chk("ifo_mem_valid", 64'(o_mem_valid), 64'(1));
        chk("ifo_mem_addr", o_mem_addr, 64'h8000_0000);
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 64'h0000_0013_0000_0297;
        step();
        chk("ifo_rsp", 64'(o_if_rsp), 64'(1));
        chk("ifo_rdata", o_if_rdata, 64'h0000_0013_0000_0297);
        chk("ifo_ls_rsp", 64'(o_ls_rsp), 64'(0));
        idle_inputs();
        step();
        chk("ifo_rsp_once", 64'(o_if_rsp), 64'(0));

        // LS write held off by memory for 5 cycles; response on the last allowed cycle.
        bus.ls_req_valid = 1'b1; bus.ls_addr = 64'h8000_3008; bus.ls_wen = 1'b1;
        bus.ls_wdata = 64'hDEAD_BEEF; bus.ls_wmask = 8'h0F;
        step();
        chk("bp_accept", 64'(o_ls_ready), 64'(1));
        bus.if_req_valid = 1'b1;
        bus.ls_wdata = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_mem_valid", 64'(o_mem_valid), 64'(1));
            chk("bp_wdata", o_mem_wdata, 64'hDEAD_BEEF);
            chk("bp_wmask", 64'(o_mem_wmask), 64'h0F);
            chk("bp_addr", o_mem_addr, 64'h8000_3008);
            chk("bp_if_ready", 64'(o_if_ready), 64'(0));
            chk("bp_ls_ready", 64'(o_ls_ready), 64'(0));
        end
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        step();
        chk("bp_wait_ls_ready", 64'(o_ls_ready), 64'(0));
        bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 64'h0;
        step();
        chk("bp_ls_ack", 64'(o_ls_rsp), 64'(1));
        chk("bp_no_err", 64'(o_err), 64'(0));
        idle_inputs();

        // Watchdog: no response ever, abort 7 cycles after entering REQ.
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_4000; bus.mem_req_ready = 1'b1;
        step();
        chk("to_accept", 64'(o_if_ready), 64'(1));
        bus.if_req_valid = 1'b0; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("to_err", 64'(o_err), 64'(i == 8));
            chk("to_if_rsp", 64'(o_if_rsp), 64'(i == 8));
            if (i == 8) chk("to_rdata", o_if_rdata, 64'(0));
        end
        bus.mem_req_ready = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_4008;
        step();
        chk("to_reaccept", 64'(o_if_ready), 64'(1));
        bus.if_req_valid = 1'b0;
        serve(0, 0, 64'h0BAD_F00D);
        chk("to_after_rsp", 64'(o_if_rsp), 64'(1));
        idle_inputs();

        // Reset while an LS read is in WAIT.
        bus.ls_req_valid = 1'b1; bus.ls_addr = 64'h8000_5000; bus.ls_wen = 1'b0;
        step();
        chk("rw_accept", 64'(o_ls_ready), 64'(1));
        bus.ls_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 64'h7777_7777;
        step();
        chk("rw_late_rsp_dropped", 64'(o_ls_rsp), 64'(0));
        chk("rw_mem_valid", 64'(o_mem_valid), 64'(0));
        chk("rw_mem_addr", o_mem_addr, 64'(0));
        chk("rw_err", 64'(o_err), 64'(0));
        bus.mem_rsp_valid = 1'b0;
        bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
        step();
        chk("rw_tie_ls", 64'(o_ls_ready), 64'(1));
        chk("rw_tie_if", 64'(o_if_ready), 64'(0));
        bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0;
        serve(0, 0, 64'h4242);
        chk("rw_rsp", 64'(o_ls_rsp), 64'(1));
        idle_inputs();

        // Randomized traffic; requesters hold a request until it is accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!bus.if_req_valid || o_if_ready) begin
                bus.if_req_valid = ($urandom_range(0, 2) == 0);
                bus.if_addr      = {$urandom, $urandom};
            end
            if (!bus.ls_req_valid || o_ls_ready) begin
                bus.ls_req_valid = ($urandom_range(0, 2) == 0);
                bus.ls_addr      = {$urandom, $urandom};
                bus.ls_wen       = $urandom_range(0, 1) == 1;
                bus.ls_wdata     = {$urandom, $urandom};
                bus.ls_wmask     = MW'($urandom);
            end
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.mem_rsp_valid = ($urandom_range(0, 3) == 0);
            bus.mem_rdata     = {$urandom, $urandom};
            rst_n             = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
